dma_ocram_dp: RTL
=================

# dma_ocram_dp

Parametrised true dual-port on-chip RAM with two independent Avalon-MM slaves (s1, s2), pipelined reads with `readdatavalid`, and write-collision arbitration. It sits beside the DMA engine so the CPU and the DMA master can access the buffer concurrently: typically CPU on s1, DMA on s2. Width, depth and read latency are generic. An optional post-reset clear sequencer zeroes the array.

## Interface
- `DATA_WIDTH`, 32: word width in bits; multiple of 8.
- `ADDR_WIDTH`, 10: word address width; depth = 2^ADDR_WIDTH.
- `READ_LATENCY`, 1: cycles from read acceptance to `readdatavalid`; legal values are 1 and 2.
- `INIT_FILE`, "dma_ocram_0.hex": initial contents; ignored when the clear feature is compiled in.

- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `clken`  in  1  global clock enable; low freezes the array and the read pipelines.
- `reset_req`  in  1  reset-request guard; high behaves as `clken` low.
- `sN_address`  in  ADDR_WIDTH  word address, N = 1, 2.
- `sN_byteenable`  in  DATA_WIDTH/8  per-byte write enable.
- `sN_chipselect`  in  1  port select.
- `sN_read`  in  1  read request.
- `sN_write`  in  1  write request.
- `sN_writedata`  in  DATA_WIDTH  write data.
- `sN_readdata`  out  DATA_WIDTH  read data; valid only while `sN_readdatavalid` is high.
- `sN_readdatavalid`  out  1  one-cycle read-return strobe.
- `sN_waitrequest`  out  1  stall; a request is accepted only in a cycle where this is low.

## Operation
- Accept on port N: `sN_chipselect & (sN_read | sN_write) & ~sN_waitrequest`.
- Both `sN_read` and `sN_write` high on one port in the same cycle: the write is performed and the read is discarded; no `readdatavalid` is produced.
- Writes update only the bytes whose `byteenable` bit is set.
- Same-address writes on s1 and s2 in one cycle: s1 has priority. `s2_waitrequest` is high that cycle and s2 retries on the next cycle. Different addresses never stall.
- Read on one port and write on the other to the same address in the same cycle: the read returns the old data.
- Each port has a READ_LATENCY-deep valid/data pipeline. Returns come back in order, one per accepted read, with no bubbles beyond the fixed latency.
- `sN_waitrequest` = `~clken | reset_req | collision (s2 only) | clearing`.
- Pipeline registers hold their contents while `clken` is low or `reset_req` is high.
- `reset` flushes both pipelines. In-flight reads are dropped and never return. Array contents are preserved unless the clear feature is compiled in.

## Timing
- Reset values: `sN_readdatavalid` = 0, `sN_readdata` = 0. `sN_waitrequest` = 0, or 1 when the clear feature is active.
- Read accepted at edge T: `sN_readdatavalid` high for exactly the cycle after edge T+READ_LATENCY. This stretches by the number of cycles in which `clken` was low in between.
- Write accepted at edge T: the data is readable by a read accepted at edge T+1.
- Throughput: one access per port per cycle.
- `waitrequest` is combinational from `clken`, `reset_req`, the addresses and the strobes.

## Configuration
- `DMA_OCRAM_CLEAR_EN` defined:
  - After `reset` deasserts, an ADDR_WIDTH-bit counter FSM (IDLE→CLEAR→READY) writes zero to addresses 0 through 2^ADDR_WIDTH−1, one per enabled cycle.
  - Both `waitrequest` outputs are high throughout CLEAR and fall in the cycle after the last address is written.
  - A `reset` during CLEAR restarts the sweep at address 0.
  - `INIT_FILE` is unused.
- `DMA_OCRAM_CLEAR_EN` undefined: no FSM, the array is initialised from `INIT_FILE`, and ports are ready in the first cycle after reset.

## Test plan
- Latency: for each READ_LATENCY value in {1, 2}, s1 writes 0xDEADBEEF to address 5 with `byteenable` = 0xF, then reads address 5. Required: `readdatavalid` exactly READ_LATENCY cycles after acceptance, with data 0xDEADBEEF.
- Byte lanes: s2 writes 0x11223344 to address 7, then writes 0xAABBCCDD with `byteenable` = 0b0101. Required: a read of address 7 returns 0x11BB33DD.
- Write collision: s1 and s2 both write address 3 (s1 0x1, s2 0x2). Required: `s2_waitrequest` high for one cycle, s2 is accepted on the next cycle, and the final read of address 3 returns 0x2.
- Cross-port read-during-write: s1 writes 0x55 to address 9 while s2 reads address 9, which previously held 0x0. Required: s2 gets 0x0 and a subsequent read gets 0x55.
- Stall and flush:
  - Back-to-back reads on s1 with `clken` dropped for 3 cycles mid-stream: all returns arrive in order, delayed by exactly 3 cycles.
  - `reset` asserted with 2 reads in flight: no `readdatavalid` is produced.
- Clear feature (`DMA_OCRAM_CLEAR_EN` defined, ADDR_WIDTH = 4): after reset, `waitrequest` stays high for 16 cycles. Reads of every address then return 0, and a reset issued at sweep address 8 restarts the full 16-cycle sweep.

Source files
------------

// File: rtl/dma_ocram_dp_if.sv
// One Avalon-MM slave port of the dual-port buffer: request fields in, pipelined read return and stall out.
interface dma_ocram_dp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic [ADDR_WIDTH-1:0]   address;
    logic [DATA_WIDTH/8-1:0] byteenable;
    logic                    chipselect;
    logic                    read;
    logic                    write;
    logic [DATA_WIDTH-1:0]   writedata;
    logic [DATA_WIDTH-1:0]   readdata;
    logic                    readdatavalid;
    logic                    waitrequest;

    modport master (
        output address, byteenable, chipselect, read, write, writedata,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, byteenable, chipselect, read, write, writedata,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/dma_ocram_dp.sv
// True dual-port on-chip RAM with two Avalon-MM slaves, READ_LATENCY-deep read pipelines and s1-priority write collisions.
// DMA_OCRAM_CLEAR_EN: post-reset sweep that zeroes the array while both ports stall.
module dma_ocram_dp #(
    parameter int    DATA_WIDTH   = 32,
    parameter int    ADDR_WIDTH   = 10,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = "dma_ocram_0.hex"
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clken,
    input  logic          reset_req,
    dma_ocram_dp_if.slave s1,
    dma_ocram_dp_if.slave s2
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic en;
    logic clearing;
    logic collision;
    logic wait1, wait2;
    logic wr1, wr2, rd1, rd2;

    assign en = clken & ~reset_req;

`ifdef DMA_OCRAM_CLEAR_EN
    typedef enum logic [1:0] {IDLE, CLEAR, READY} clr_state_t;

    clr_state_t            state, state_nxt;
    logic [ADDR_WIDTH-1:0] clr_cnt, clr_cnt_nxt;
    logic                  clr_we;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    // IDLE already writes address 0 so the sweep stalls the ports for exactly DEPTH cycles.
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        clr_we      = 1'b0;
        case (state)
            IDLE, CLEAR: begin
                if (en && !reset) begin
                    clr_we      = 1'b1;
                    clr_cnt_nxt = clr_cnt + 1'b1;
                    state_nxt   = (clr_cnt == '1) ? READY : CLEAR;
                end
            end
            default: ;
        endcase
    end

    assign clearing = (state != READY);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
`else
    assign clearing = 1'b0;

    (* ram_init_file = INIT_FILE *) logic [DATA_WIDTH-1:0] mem [DEPTH];
`endif

    assign collision = s1.chipselect & s1.write & s2.chipselect & s2.write &
                       (s1.address == s2.address);

    assign wait1 = ~en | clearing;
    assign wait2 = ~en | clearing | collision;

    assign s1.waitrequest = wait1;
    assign s2.waitrequest = wait2;

    // A simultaneous read+write on one port performs only the write.
    assign wr1 = s1.chipselect & s1.write & ~wait1;
    assign wr2 = s2.chipselect & s2.write & ~wait2;
    assign rd1 = s1.chipselect & s1.read & ~s1.write & ~wait1;
    assign rd2 = s2.chipselect & s2.read & ~s2.write & ~wait2;

    always_ff @(posedge clk) begin
`ifdef DMA_OCRAM_CLEAR_EN
        if (clr_we) mem[clr_cnt] <= '0;
`endif
        for (int b = 0; b < NB; b++) begin
            if (wr2 && s2.byteenable[b]) mem[s2.address][b*8 +: 8] <= s2.writedata[b*8 +: 8];
            if (wr1 && s1.byteenable[b]) mem[s1.address][b*8 +: 8] <= s1.writedata[b*8 +: 8];
        end
    end

    logic [READ_LATENCY-1:0] vld1, vld2;
    logic [DATA_WIDTH-1:0]   dat1 [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   dat2 [READ_LATENCY];

    // Non-blocking read of mem gives the pre-write word on a same-cycle cross-port write.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld1 <= '0;
            vld2 <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                dat1[i] <= '0;
                dat2[i] <= '0;
            end
        end else if (en) begin
            vld1[0] <= rd1;
            vld2[0] <= rd2;
            if (rd1) dat1[0] <= mem[s1.address];
            if (rd2) dat2[0] <= mem[s2.address];
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld1[i] <= vld1[i-1];
                vld2[i] <= vld2[i-1];
                dat1[i] <= dat1[i-1];
                dat2[i] <= dat2[i-1];
            end
        end
    end

    assign s1.readdata      = dat1[READ_LATENCY-1];
    assign s1.readdatavalid = vld1[READ_LATENCY-1];
    assign s2.readdata      = dat2[READ_LATENCY-1];
    assign s2.readdatavalid = vld2[READ_LATENCY-1];
endmodule
